probe_demuxer: RTL and testbench
================================

Name: probe_demuxer

Overview:
- Inverse of the one-hot probe muxer: takes one serial probe bit stream plus a one-hot channel select.
- Steers each bit into one of N per-channel deserialisers.
- Presents completed W-bit words per channel, each with a one-cycle valid pulse.
- Sits on the probe return path, between the serial probe link and per-channel capture logic.

Parameters:
- N, 4, number of channels; width of sw and dout_valid.
- W, 8, bits per deserialised word (W >= 2).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sw  input  N  one-hot channel select; sw[k]=1 routes din to channel k.
- din  input  1  serial probe data bit.
- din_valid  input  1  din is sampled this cycle.
- clear  input  1  synchronous flush of partial words and error count.
- dout  output  N*W  completed words; channel k occupies bits [k*W+W-1 : k*W].
- dout_valid  output  N  one-cycle pulse per channel when its dout slice updates.
- sel_err  output  1  one-cycle pulse when a bit is dropped for a bad select.
- err_cnt  output  8  saturating count of dropped bits.

Behaviour:
- Reset (rst_n low, async): all shift registers, bit counters, dout, dout_valid, sel_err and err_cnt go to 0. This applies immediately, mid-word included. The partial word is discarded.
- Each channel k has a W-bit shift register sr[k] and a bit counter cnt[k] of clog2(W) bits.
- Channel states:
  - IDLE: cnt[k]=0.
  - COLLECT: 0 < cnt[k] < W.
- Accepted bit (din_valid=1 and sw has exactly one bit set, at index k):
  - sr[k] <= {sr[k][W-2:0], din}. The stream is MSB-first.
  - If cnt[k] < W-1, then cnt[k] increments.
  - If cnt[k] == W-1 (word complete):
    - dout slice k <= {sr[k][W-2:0], din} at the same edge.
    - dout_valid[k] = 1 for exactly that following cycle.
    - cnt[k] <= 0 (wrap back to IDLE).
- Latency: the word and its valid are visible in the cycle after the edge that samples the last bit.
- Channels not selected hold sr and cnt unchanged, so interleaved streams are legal. Each channel resumes where it left off.
- dout slices hold their value until that channel completes its next word.
- Only one channel can complete per cycle, so at most one dout_valid bit is high.
- Bad select: din_valid=1 and sw is not one-hot (zero bits or two or more bits set).
  - The bit is dropped and no channel state changes.
  - sel_err pulses for 1 cycle.
  - err_cnt increments, saturating at 255 (stays at 255).
- din_valid=0: sw and din are ignored. No state change and no error. All pulse outputs return to 0.
- clear=1, synchronous:
  - All cnt and sr go to 0 and err_cnt goes to 0. dout is retained.
  - dout_valid and sel_err go to 0 next cycle.
  - clear wins over din_valid in the same cycle: the bit is dropped, with no error and no count.
- The 1-cycle pulse outputs are driven from registers, never combinationally from inputs.

Test Plan:
- Reset, then send 8 bits 1,0,1,0,0,1,0,1 with sw=4'b0001, din_valid=1 every cycle.
  - Expect dout[7:0]=8'hA5 and dout_valid=4'b0001 for one cycle, one cycle after the 8th bit.
  - Expect the other dout slices to stay 0.
- Interleave: 4 bits of 8'hF0 on ch2, then 8 bits of 8'h3C on ch1, then the remaining 4 bits of ch2.
  - Expect ch1 to deliver 8'h3C first, then ch2 to deliver 8'hF0.
  - Expect exactly two single-cycle valid pulses.
- Bad select: sw=4'b0000, then sw=4'b0011, both with din_valid=1.
  - Expect two sel_err pulses, err_cnt=2 and no channel progress. A following clean 8-bit word still decodes correctly.
- Saturation: 300 consecutive bad-select bits.
  - Expect err_cnt=255 and sel_err to pulse on every one of those cycles.
  - Then assert clear and expect err_cnt=0.
- Flush: 5 bits into ch3, then clear=1 with din_valid=1, then 8 bits of 8'h81.
  - Expect dout slice 3 = 8'h81, proving the partial word was discarded.
  - Expect the earlier dout values of other channels unchanged.
- Async reset: drop rst_n mid-word (after 3 bits on ch0) asynchronously to clk.
  - Expect all outputs 0 immediately.
  - After release, expect a new 8-bit word on ch0 to decode exactly.

Source files
------------

// File: rtl/probe_demuxer_if.sv
// Bus between the serial probe return link and the per-channel capture side.
// master: the link side, which drives select, data and flush.
// slave: the demuxer, which returns the words, the pulses and the error count.
interface probe_demuxer_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic [N-1:0]   sw;
  logic           din;
  logic           din_valid;
  logic           clear;
  logic [N*W-1:0] dout;
  logic [N-1:0]   dout_valid;
  logic           sel_err;
  logic [7:0]     err_cnt;

  modport master (
    output sw, din, din_valid, clear,
    input  dout, dout_valid, sel_err, err_cnt
  );

  modport slave (
    input  sw, din, din_valid, clear,
    output dout, dout_valid, sel_err, err_cnt
  );
endinterface

// File: rtl/probe_demuxer.sv
// Probe demuxer: steers a serial MSB-first probe stream into N per-channel
// deserialisers using a one-hot select. Each channel presents its completed
// W-bit word with a one-cycle valid pulse. Bits that arrive with a select
// that is not one-hot are dropped, flagged and counted (the count saturates).
module probe_demuxer #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  probe_demuxer_if.slave    bus
);
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [W-1:0]  sr      [N];
  logic [CW-1:0] cnt     [N];
  logic [W-1:0]  dout_q  [N];
  logic [N-1:0]  dout_valid_q;
  logic          sel_err_q;
  logic [7:0]    err_cnt_q;

  logic          one_hot;
  logic          bad_sel;
  logic [N-1:0]  accept;

  // A select is usable only with exactly one bit set.
  assign one_hot = (bus.sw != '0) && ((bus.sw & (bus.sw - N'(1))) == '0);

  // clear beats din_valid, so a flushed bit is neither accepted nor an error.
  assign bad_sel = bus.din_valid & ~bus.clear & ~one_hot;

  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    assign accept[gi]               = bus.din_valid & ~bus.clear & one_hot & bus.sw[gi];
    assign bus.dout[gi*W +: W]      = dout_q[gi];
  end

  assign bus.dout_valid = dout_valid_q;
  assign bus.sel_err    = sel_err_q;
  assign bus.err_cnt    = err_cnt_q;

  // Per-channel shift/count state, word capture and the registered valid pulse.
  // Unselected channels keep their partial words, so streams may interleave.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        sr[k]     <= '0;
        cnt[k]    <= '0;
        dout_q[k] <= '0;
      end
      dout_valid_q <= '0;
    end else if (bus.clear) begin
      // Partial words are discarded; completed words in dout are kept.
      for (int k = 0; k < N; k++) begin
        sr[k]  <= '0;
        cnt[k] <= '0;
      end
      dout_valid_q <= '0;
    end else begin
      dout_valid_q <= '0;
      for (int k = 0; k < N; k++) begin
        if (accept[k]) begin
          sr[k] <= {sr[k][W-2:0], bus.din};
          if (cnt[k] == LAST) begin
            cnt[k]          <= '0;
            dout_q[k]       <= {sr[k][W-2:0], bus.din};
            dout_valid_q[k] <= 1'b1;
          end else begin
            cnt[k] <= cnt[k] + CW'(1);
          end
        end
      end
    end
  end

  // Bad-select pulse and saturating dropped-bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else if (bus.clear) begin
      sel_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      sel_err_q <= bad_sel;
      if (bad_sel && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_probe_demuxer.sv
// Scoreboard bench for probe_demuxer: the stimulus pushes each expected word
// (channel, value, completion cycle) when it sends the last bit; a negedge
// monitor pops and checks whenever dout_valid is seen.
module tb_probe_demuxer;
  localparam int N = 4;
  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  probe_demuxer_if #(.N(N), .W(W)) bus ();

  probe_demuxer #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int           ch;
    logic [W-1:0] word;
    int           due;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] shadow [N];
  int           vectors  = 0;
  int           errors   = 0;
  int           cyc      = 0;
  int           pulses   = 0;
  int           sel_seen = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [N*W-1:0] packed_shadow();
    logic [N*W-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r[k*W +: W] = shadow[k];
    return r;
  endfunction

  // Monitor: every valid pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.sel_err) sel_seen++;
      if (bus.dout_valid != '0) begin
        pulses++;
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_valid dout_valid=%b dout=%h cyc=%0d", bus.dout_valid, bus.dout, cyc);
        end else begin
          e = exp_q.pop_front();
          shadow[e.ch] = e.word;
          chk("valid_bits", 64'(bus.dout_valid), 64'(N'(1) << e.ch));
          chk("dout_word", 64'(bus.dout), 64'(packed_shadow()));
          chk("latency_cycle", 64'(cyc), 64'(e.due));
        end
      end
    end
  end

  task automatic drive(input logic [N-1:0] s, input logic d, input logic v, input logic c);
    bus.sw        = s;
    bus.din       = d;
    bus.din_valid = v;
    bus.clear     = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, 1'b0, 1'b0, 1'b0);
  endtask

  // Sends bits hi..lo of word on channel ch; bit 0 completes the word.
  task automatic send_range(input int ch, input logic [W-1:0] word, input int hi, input int lo);
    exp_t e;
    for (int i = hi; i >= lo; i--) begin
      if (i == 0) begin
        e.ch   = ch;
        e.word = word;
        e.due  = cyc + 1;
        exp_q.push_back(e);
      end
      drive(N'(1) << ch, word[i], 1'b1, 1'b0);
    end
  endtask

  task automatic send_word(input int ch, input logic [W-1:0] word);
    send_range(ch, word, W - 1, 0);
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog time limit reached at t=%0t", $time);
    summary();
    $finish;
  end

  initial begin
    int p0;
    int s0;
    for (int k = 0; k < N; k++) shadow[k] = '0;
    bus.sw = '0; bus.din = 1'b0; bus.din_valid = 1'b0; bus.clear = 1'b0;

    // Reset state.
    #12;
    chk("reset_dout", 64'(bus.dout), 64'd0);
    chk("reset_valid", 64'(bus.dout_valid), 64'd0);
    chk("reset_sel_err", 64'(bus.sel_err), 64'd0);
    chk("reset_err_cnt", 64'(bus.err_cnt), 64'd0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single word on ch0: 1,0,1,0,0,1,0,1 = A5.
    send_word(0, 8'hA5);
    idle(3);
    chk("t1_pulses", 64'(pulses), 64'd1);

    // Interleave: half of F0 on ch2, full 3C on ch1, rest of F0 on ch2.
    p0 = pulses;
    send_range(2, 8'hF0, 7, 4);
    send_word(1, 8'h3C);
    send_range(2, 8'hF0, 3, 0);
    idle(3);
    chk("t2_pulses", 64'(pulses - p0), 64'd2);

    // Bad selects: none and two bits set.
    s0 = sel_seen;
    drive(4'b0000, 1'b1, 1'b1, 1'b0);
    drive(4'b0011, 1'b1, 1'b1, 1'b0);
    idle(2);
    chk("t3_sel_pulses", 64'(sel_seen - s0), 64'd2);
    chk("t3_err_cnt", 64'(bus.err_cnt), 64'd2);
    send_word(0, 8'h5A);
    idle(3);

    // Saturation: 300 bad bits, then clear.
    s0 = sel_seen;
    for (int i = 0; i < 300; i++) drive(4'b0110, 1'b0, 1'b1, 1'b0);
    idle(2);
    chk("t4_sel_pulses", 64'(sel_seen - s0), 64'd300);
    chk("t4_err_sat", 64'(bus.err_cnt), 64'd255);
    drive('0, 1'b0, 1'b0, 1'b1);
    chk("t4_err_cleared", 64'(bus.err_cnt), 64'd0);

    // Flush: 5 bits on ch3, clear with a valid bit, then 81.
    s0 = sel_seen;
    send_range(3, 8'hB7, 7, 3);
    drive(4'b1000, 1'b1, 1'b1, 1'b1);
    chk("t5_clear_no_err", 64'(bus.err_cnt), 64'd0);
    send_word(3, 8'h81);
    idle(3);
    chk("t5_no_sel_err", 64'(sel_seen - s0), 64'd0);
    chk("t5_ch3", 64'(bus.dout[4*W-1:3*W]), 64'h81);
    chk("t5_others", 64'(bus.dout[3*W-1:0]), 64'hF03C5A);

    // Async reset mid-word on ch0, away from any clock edge.
    send_range(0, 8'hC3, 7, 5);
    bus.din_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_dout", 64'(bus.dout), 64'd0);
    chk("t6_rst_valid", 64'(bus.dout_valid), 64'd0);
    chk("t6_rst_sel_err", 64'(bus.sel_err), 64'd0);
    chk("t6_rst_err_cnt", 64'(bus.err_cnt), 64'd0);
    for (int k = 0; k < N; k++) shadow[k] = '0;
    #7 rst_n = 1'b1;
    @(posedge clk); #1;
    send_word(0, 8'h96);
    idle(3);
    chk("t6_ch0_after_rst", 64'(bus.dout[W-1:0]), 64'h96);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    summary();
    $finish;
  end
endmodule
